mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  MEM-stage load/store unit between the ex_mem register and the mem_wb register.
//  - Turns each load/store into one handshaked data-bus transaction.
//  - Stalls the pipeline until the transaction completes.
//  - Sign/zero-extends load data and presents it as in_readData to mem_wb.
//  - Flags misaligned, illegal-size and timed-out accesses.
// PARAMETERS
//  TIMEOUT_CYC  16  max REQ-state cycles waiting on bus_ready before abort (>=1)
//  CNT_W        5   width of timeout counter; must hold TIMEOUT_CYC
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  in_valid       in   1   instruction present in MEM stage
//  in_memRead     in   1   load
//  in_memWrite    in   1   store (memRead and memWrite both 1 -> treated as illegal)
//  in_memSize     in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  in_addr        in   32  byte address (ALU result)
//  in_wdata       in   32  store data (rs2)
//  bus_req        out  1   bus request, registered
//  bus_we         out  1   1 = write, registered
//  bus_addr       out  32  word-aligned address {in_addr[31:2],2'b00}, registered
//  bus_wdata      out  32  lane-replicated store data, registered
//  bus_wstrb      out  4   byte write strobes, 0 for reads, registered
//  bus_ready      in   1   transaction complete this cycle
//  bus_rdata      in   32  read word, valid when bus_ready && !bus_we
//  data_readData  out  32  formatted load data to mem_wb in_readData
//  mem_stall      out  1   hold IF..EX/MEM; upstream keeps in_* stable while 1
//  mem_fault      out  1   one-cycle pulse: misaligned, illegal size/op, or timeout
// BEHAVIOUR
//  Reset (async): state=IDLE; every registered output and counter is 0.
//   mem_stall and mem_fault are forced 0 while reset is high.
//   Reset mid-transaction drops bus_req at once; no completion is reported.
//  access = in_valid & (in_memRead ^ in_memWrite).
//  bad    = illegal funct3 (011/110/111), or both read and write asserted,
//           or H/HU with addr[0]=1, or W with addr[1:0]!=0.
//  FSM IDLE/REQ/DONE:
//   IDLE: access & !bad -> load bus_* regs, REQ; mem_stall=1 (combinational).
//         access & bad -> stay IDLE; mem_fault=1 this cycle; data_readData=0;
//         mem_stall=0 (no bus traffic).
//         no access -> stay IDLE; mem_stall=0; data_readData unchanged.
//   REQ:  bus_req=1; all bus_* held stable; mem_stall=1; counter increments.
//         bus_ready -> bus_req<=0; on reads, capture formatted rdata; go DONE.
//         counter==TIMEOUT_CYC-1 && !bus_ready -> abort: bus_req<=0,
//         data_readData<=0, mem_fault pulses in DONE, go DONE.
//   DONE: mem_stall=0 (pipeline advances; mem_wb latches data_readData); go IDLE.
//         Counter clears on every DONE->IDLE transition.
//  Minimum latency: 3 cycles (IDLE, REQ with ready, DONE); +1 cycle per wait.
//  Stores: B -> wstrb=4'b0001<<addr[1:0], wdata={4{b}};
//          H -> wstrb=4'b0011<<addr[1:0], wdata={2{h}};
//          W -> wstrb=4'b1111, wdata=in_wdata.
//  Loads: select byte/half by addr[1:0]; B/H sign-extend, BU/HU zero-extend to 32.
//   Load results are formatted from the addr[1:0] and size latched in IDLE.
//  data_readData holds its last value between accesses. Stores leave it unchanged.
// STRUCTURE
//  Shared include mem_defs.vh holds:
//   funct3 size codes (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU);
//   FSM state encodings (ST_IDLE, ST_REQ, ST_DONE);
//   default TIMEOUT_CYC.
//  Sub-module load_align (combinational): inputs rdata, addr[1:0], size;
//   output 32-bit extended value. The same module is reused by the bench model.
//  Top level holds the FSM, timeout counter, store lane and strobe logic,
//   and the output registers.
// TESTING
//  LW addr 0x100, rdata 0xDEADBEEF, ready in 1st REQ cycle -> stall for 2 cycles;
//   data_readData=0xDEADBEEF in DONE.
//  LB addr 0x103, rdata 0x80FF_0000 -> 0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr 0x202, wdata 0x1234ABCD -> bus_wstrb=4'b1100, bus_wdata=0xABCDABCD,
//   bus_addr=0x200, bus_we=1.
//  LW addr 0x101 -> no bus_req, mem_fault=1 for 1 cycle, mem_stall=0,
//   data_readData=0.
//  LW with bus_ready held low -> bus_req drops after 16 REQ cycles;
//   mem_fault=1 and data_readData=0 in DONE; next access proceeds normally.
//  Assert reset during REQ -> bus_req=0 same cycle, state IDLE, mem_stall=0;
//   after release a fresh SW completes correctly.

Source files
------------

// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the MEM-stage load/store unit:
//   - funct3 access-size codes (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU)
//   - FSM state type (ST_IDLE, ST_REQ, ST_DONE)
//   - default bus timeout and counter width
//   - helpers for size legality, alignment and store lane formatting
// -----------------------------------------------------------------------------
package mem_access_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    localparam int DEFAULT_TIMEOUT_CYC = 16;
    localparam int DEFAULT_CNT_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Only the five RV32 load/store widths are accepted.
    function automatic logic size_legal(input logic [2:0] f3);
        case (f3)
            MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // sz is funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across all lanes so the strobes alone pick
    // the bytes that land in memory.
    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] wdata);
        case (sz)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// -----------------------------------------------------------------------------
// mem_access_if
// Handshaked data bus between the MEM stage (master) and memory (slave).
//   req    master->slave  transaction request, held until ready
//   we     master->slave  1 = write
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  lane-replicated store data
//   wstrb  master->slave  byte write strobes, 0 for reads
//   ready  slave->master  transaction completes this cycle
//   rdata  slave->master  read word, valid when ready && !we
// -----------------------------------------------------------------------------
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/mem_access_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load formatter: picks the addressed byte/half out of the
// read word and sign- or zero-extends it to 32 bits.
//   rdata  in  32  raw read word from the bus
//   off    in  2   byte offset within the word (addr[1:0])
//   size   in  3   funct3 load size
//   value  out 32  extended result; 0 for an illegal size
// -----------------------------------------------------------------------------
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    output logic [31:0] value
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    // Moving the addressed lane down to bit 0 lets one mux handle all offsets.
    assign shifted = rdata >> {off, 3'b000};
    assign b       = shifted[7:0];
    assign h       = shifted[15:0];

    // NOTE: a default assignment ahead of the case keeps this purely
    // combinational; a path that leaves value unassigned would infer a latch.
    always_comb begin
        value = '0;
        case (size)
            MEM_B:   value = {{24{b[7]}}, b};
            MEM_H:   value = {{16{h[15]}}, h};
            MEM_W:   value = rdata;
            MEM_BU:  value = {24'h0, b};
            MEM_HU:  value = {16'h0, h};
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// MEM-stage load/store unit between ex_mem and mem_wb. Each load/store becomes
// one handshaked bus transaction; the pipeline is stalled until it completes,
// load data is formatted for mem_wb, and misaligned, illegal and timed-out
// accesses raise a one-cycle fault.
//   clk, reset         clock, asynchronous active-high reset
//   in_valid           instruction present in MEM
//   in_memRead/Write   load / store (both set is illegal)
//   in_memSize         funct3 size code
//   in_addr, in_wdata  byte address and store data
//   bus                master side of the data bus (registered outputs)
//   data_readData      formatted load data to mem_wb
//   mem_stall          hold upstream stages; in_* stay stable while 1
//   mem_fault          one-cycle fault pulse
// -----------------------------------------------------------------------------
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_memRead,
    input  logic               in_memWrite,
    input  logic [2:0]         in_memSize,
    input  logic [31:0]        in_addr,
    input  logic [31:0]        in_wdata,
    mem_access_if.master       bus,
    output logic [31:0]        data_readData,
    output logic               mem_stall,
    output logic               mem_fault
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              tmo_q;
    logic              lat_rd_q;
    logic [1:0]        lat_off_q;
    logic [2:0]        lat_size_q;
    logic [31:0]       rd_q;
    logic [31:0]       load_val;

    logic              any_op;
    logic              access;
    logic              bad;
    logic              go_req;
    logic              illegal;
    logic              finish_ok;
    logic              abort;
    logic              stall_c;
    logic              fault_c;

    // Decode of the instruction currently sitting in MEM.
    assign any_op = in_valid & (in_memRead | in_memWrite);
    assign access = in_valid & (in_memRead ^ in_memWrite);
    assign bad    = ~size_legal(in_memSize)
                  | (in_memRead & in_memWrite)
                  | misaligned(in_memSize[1:0], in_addr[1:0]);

    load_align u_align (
        .rdata (bus.rdata),
        .off   (lat_off_q),
        .size  (lat_size_q),
        .value (load_val)
    );

    // Next state and the combinational stall/fault outputs.
    always_comb begin
        state_d   = state_q;
        go_req    = 1'b0;
        illegal   = 1'b0;
        finish_ok = 1'b0;
        abort     = 1'b0;
        stall_c   = 1'b0;
        fault_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (access && !bad) begin
                    go_req  = 1'b1;
                    stall_c = 1'b1;
                    state_d = ST_REQ;
                end else if (any_op && bad) begin
                    // Rejected without bus traffic; the pipeline moves on.
                    illegal = 1'b1;
                    fault_c = 1'b1;
                end
            end
            ST_REQ: begin
                stall_c = 1'b1;
                if (bus.ready) begin
                    finish_ok = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    abort   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Timeout fault is reported here, alongside the zeroed data.
                fault_c = tmo_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
            lat_rd_q   <= 1'b0;
            lat_off_q  <= 2'b00;
            lat_size_q <= 3'b000;
            rd_q       <= '0;
            bus.req    <= 1'b0;
            bus.we     <= 1'b0;
            bus.addr   <= '0;
            bus.wdata  <= '0;
            bus.wstrb  <= '0;
        end else begin
            state_q <= state_d;

            if (go_req) begin
                bus.req    <= 1'b1;
                bus.we     <= in_memWrite;
                bus.addr   <= {in_addr[31:2], 2'b00};
                bus.wdata  <= lane_data(in_memSize[1:0], in_wdata);
                bus.wstrb  <= in_memWrite ? lane_strb(in_memSize[1:0], in_addr[1:0]) : 4'b0000;
                // Load formatting uses these latched copies, not live in_*.
                lat_rd_q   <= in_memRead;
                lat_off_q  <= in_addr[1:0];
                lat_size_q <= in_memSize;
            end

            if (illegal) begin
                rd_q <= '0;
            end

            if (state_q == ST_REQ) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (finish_ok) begin
                bus.req <= 1'b0;
                if (lat_rd_q) begin
                    rd_q <= load_val;
                end
            end

            if (abort) begin
                bus.req <= 1'b0;
                rd_q    <= '0;
                tmo_q   <= 1'b1;
            end

            if (state_q == ST_DONE) begin
                cnt_q <= '0;
                tmo_q <= 1'b0;
            end
        end
    end

    // An illegal access shows zero in the same cycle it is rejected, since
    // mem_wb latches at the end of that cycle.
    assign data_readData = illegal ? 32'h0 : rd_q;
    assign mem_stall     = stall_c & ~reset;
    assign mem_fault     = fault_c & ~reset;

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
// Self-checking bench for mem_access. A reference model written from the
// access rules (byte counts, modular offsets, shifts) predicts strobes, lane
// data, load results, faults and the held data_readData value.
// -----------------------------------------------------------------------------
module tb_mem_access;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_memRead;
    logic        in_memWrite;
    logic [2:0]  in_memSize;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [31:0] data_readData;
    logic        mem_stall;
    logic        mem_fault;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_rd = 32'h0;

    mem_access_if bus_if ();

    mem_access #(.TIMEOUT_CYC(TMO), .CNT_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_memRead    (in_memRead),
        .in_memWrite   (in_memWrite),
        .in_memSize    (in_memSize),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .bus           (bus_if.master),
        .data_readData (data_readData),
        .mem_stall     (mem_stall),
        .mem_fault     (mem_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] size);
        return 1 << size[1:0];
    endfunction

    function automatic bit model_bad(input logic rd, input logic wr,
                                     input logic [2:0] size, input logic [31:0] addr);
        if (rd && wr) return 1;
        if (!(size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1;
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] size, input logic [31:0] addr);
        int n = nbytes(size);
        int m = (1 << n) - 1;
        return 4'(m << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] r = 0;
        int n = nbytes(size);
        for (int i = 0; i < 4; i++) begin
            r = r | (((wdata >> (8 * (i % n))) & 32'hFF) << (8 * i));
        end
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int n = nbytes(size);
        logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1);
        logic [31:0] v = (rdata >> (8 * (addr % 4))) & mask;
        bit is_signed = (size == 3'd0) || (size == 3'd1);
        if (is_signed && ((v >> (8 * n - 1)) & 1)) v = v | ~mask;
        return v;
    endfunction

    // ---------------- transaction driver + checker ----------------
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int wait_n, input string name);
        bit is_bad;
        bit tmo;
        @(negedge clk);
        in_valid = 1'b1; in_memRead = rd; in_memWrite = wr;
        in_memSize = size; in_addr = addr; in_wdata = wdata;
        bus_if.ready = 1'b0;
        #1;
        is_bad = model_bad(rd, wr, size, addr);
        if (is_bad) begin
            exp_rd = 32'h0;
            total++;
            if (mem_stall !== 1'b0 || mem_fault !== 1'b1 || data_readData !== 32'h0) begin
                bad++;
                $display("FAIL %s reject: stall=%b fault=%b data=%h, want stall=0 fault=1 data=0",
                         name, mem_stall, mem_fault, data_readData);
            end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            total++;
            if (bus_if.req !== 1'b0 || mem_fault !== 1'b0 || data_readData !== exp_rd) begin
                bad++;
                $display("FAIL %s after reject: req=%b fault=%b data=%h, want req=0 fault=0 data=%h",
                         name, bus_if.req, mem_fault, data_readData, exp_rd);
            end
            return;
        end

        total++;
        if (mem_stall !== 1'b1 || mem_fault !== 1'b0 || bus_if.req !== 1'b0) begin
            bad++;
            $display("FAIL %s idle-accept: stall=%b fault=%b req=%b, want stall=1 fault=0 req=0",
                     name, mem_stall, mem_fault, bus_if.req);
        end

        tmo = (wait_n >= TMO);
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            total++;
            if (bus_if.req !== 1'b1 || bus_if.we !== wr || mem_stall !== 1'b1 || mem_fault !== 1'b0 ||
                bus_if.addr !== {addr[31:2], 2'b00} ||
                bus_if.wstrb !== (wr ? model_strb(size, addr) : 4'b0000) ||
                (wr && bus_if.wdata !== model_wdata(size, wdata))) begin
                bad++;
                $display("FAIL %s req-cycle %0d: req=%b we=%b addr=%h wstrb=%b wdata=%h stall=%b fault=%b, want req=1 we=%b addr=%h wstrb=%b wdata=%h stall=1 fault=0",
                         name, n, bus_if.req, bus_if.we, bus_if.addr, bus_if.wstrb, bus_if.wdata,
                         mem_stall, mem_fault, wr, {addr[31:2], 2'b00},
                         wr ? model_strb(size, addr) : 4'b0000, model_wdata(size, wdata));
            end
            if (n == wait_n) begin
                bus_if.ready = 1'b1;
                bus_if.rdata = rdata;
                break;
            end
            bus_if.rdata = $urandom;
        end

        @(negedge clk);
        bus_if.ready = 1'b0;
        #1;
        if (tmo) exp_rd = 32'h0;
        else if (rd) exp_rd = model_load(size, addr, rdata);
        total++;
        if (bus_if.req !== 1'b0 || mem_stall !== 1'b0 || mem_fault !== tmo || data_readData !== exp_rd) begin
            bad++;
            $display("FAIL %s done: req=%b stall=%b fault=%b data=%h, want req=0 stall=0 fault=%b data=%h",
                     name, bus_if.req, mem_stall, mem_fault, data_readData, tmo, exp_rd);
        end
    endtask

    task automatic idle_cycle(input string name);
        @(negedge clk);
        in_valid = 1'b0;
        in_memRead = $urandom_range(0, 1);
        in_memWrite = $urandom_range(0, 1);
        in_memSize = 3'($urandom);
        in_addr = $urandom;
        in_wdata = $urandom;
        #1;
        total++;
        if (mem_stall !== 1'b0 || mem_fault !== 1'b0 || bus_if.req !== 1'b0 || data_readData !== exp_rd) begin
            bad++;
            $display("FAIL %s idle: stall=%b fault=%b req=%b data=%h, want 0 0 0 data=%h",
                     name, mem_stall, mem_fault, bus_if.req, data_readData, exp_rd);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1; in_memRead = 1'b1; in_memWrite = 1'b0;
        in_memSize = 3'b010; in_addr = 32'h100; in_wdata = 32'h0;
        bus_if.ready = 1'b0; bus_if.rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (bus_if.req !== 1'b0 || bus_if.we !== 1'b0 || bus_if.addr !== 32'h0 ||
            bus_if.wdata !== 32'h0 || bus_if.wstrb !== 4'h0 || data_readData !== 32'h0 ||
            mem_stall !== 1'b0 || mem_fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h wstrb=%b data=%h stall=%b fault=%b, want all 0",
                     bus_if.req, bus_if.we, bus_if.addr, bus_if.wdata, bus_if.wstrb,
                     data_readData, mem_stall, mem_fault);
        end
        in_valid = 1'b0;
        reset = 1'b0;
        exp_rd = 32'h0;
        idle_cycle("post_reset");
    endtask

    task automatic test_directed();
        do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw_0x100");
        total++;
        if (data_readData !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL lw_value: got %h want DEADBEEF", data_readData);
        end
        idle_cycle("lw_hold");
        do_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, "lb_0x103");
        total++;
        if (data_readData !== 32'hFFFFFF80) begin
            bad++;
            $display("FAIL lb_value: got %h want FFFFFF80", data_readData);
        end
        do_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 2, "lbu_0x103");
        total++;
        if (data_readData !== 32'h00000080) begin
            bad++;
            $display("FAIL lbu_value: got %h want 00000080", data_readData);
        end
        do_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, "sh_0x202");
        total++;
        if (data_readData !== 32'h00000080) begin
            bad++;
            $display("FAIL sh_keeps_data: got %h want 00000080", data_readData);
        end
        do_access(1, 0, 3'b101, 32'h2, 32'h0, 32'h9ABC1234, 0, "lhu_hi");
        do_access(1, 0, 3'b001, 32'h2, 32'h0, 32'h9ABC1234, 0, "lh_hi");
        do_access(0, 1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 1, "sb_0x301");
        idle_cycle("directed_end");
    endtask

    task automatic test_faults();
        do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'h11223344, 0, "lw_prime");
        do_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, "lw_misaligned");
        do_access(1, 0, 3'b101, 32'h103, 32'h0, 32'h0, 0, "lhu_misaligned");
        do_access(0, 1, 3'b011, 32'h100, 32'h0, 32'h0, 0, "illegal_size");
        do_access(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, "rd_and_wr");
        idle_cycle("faults_end");
    endtask

    task automatic test_timeout();
        do_access(1, 0, 3'b010, 32'h40, 32'h0, 32'h55AA55AA, 0, "lw_prime2");
        do_access(1, 0, 3'b010, 32'h44, 32'h0, 32'h0, 99, "lw_timeout");
        idle_cycle("timeout_idle");
        do_access(1, 0, 3'b010, 32'h48, 32'h0, 32'hCAFEF00D, 3, "lw_after_timeout");
        do_access(1, 0, 3'b010, 32'h4C, 32'h0, 32'h0BADCAFE, TMO - 1, "lw_last_cycle");
        idle_cycle("timeout_end");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_memRead = 1'b0; in_memWrite = 1'b1;
        in_memSize = 3'b010; in_addr = 32'h500; in_wdata = 32'h01020304;
        bus_if.ready = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (bus_if.req !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_pre: req=%b want 1", bus_if.req);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if (bus_if.req !== 1'b0 || mem_stall !== 1'b0 || mem_fault !== 1'b0 || data_readData !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset: req=%b stall=%b fault=%b data=%h, want all 0",
                     bus_if.req, mem_stall, mem_fault, data_readData);
        end
        exp_rd = 32'h0;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        idle_cycle("mid_reset_idle");
        do_access(0, 1, 3'b010, 32'h504, 32'h89ABCDEF, 32'h0, 1, "sw_after_reset");
        idle_cycle("mid_reset_end");
    endtask

    task automatic test_back_to_back();
        do_access(1, 0, 3'b000, 32'h10, 32'h0, 32'h0000007F, 0, "b2b_lb");
        do_access(0, 1, 3'b010, 32'h14, 32'hFEEDBEEF, 32'h0, 0, "b2b_sw");
        do_access(1, 0, 3'b001, 32'h16, 32'h0, 32'h8001FFFF, 0, "b2b_lh");
        do_access(1, 0, 3'b010, 32'h17, 32'h0, 32'h0, 0, "b2b_bad");
        do_access(1, 0, 3'b100, 32'h11, 32'h0, 32'h0000F100, 0, "b2b_lbu");
        idle_cycle("b2b_end");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic rd, wr;
            logic [2:0] size;
            logic [31:0] addr;
            int w;
            int sel = $urandom_range(0, 9);
            rd = (sel < 5) || (sel == 9);
            wr = (sel >= 5);
            size = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'h1 << size[1:0]) - 1);
            w = ($urandom_range(0, 19) == 0) ? 50 : $urandom_range(0, 4);
            do_access(rd, wr, size, addr, $urandom, $urandom, w, "rand");
            if ($urandom_range(0, 2) == 0) idle_cycle("rand_idle");
        end
        idle_cycle("rand_end");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_faults();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
